rf_alu_sequencer: RTL
=====================

// Module: rf_alu_sequencer
// PURPOSE
//  Multi-cycle initiator for the RF_plus_ALU datapath: accepts one register-op
//  instruction via valid/ready, drives read addresses and ALU controls, captures
//  Y and Z/N/C/V, then writes Y back into the register file. Sits between the
//  instruction decode and RF_plus_ALU; it is the sole driver of its write port.
// PARAMETERS
//  DATA_W  16  datapath / Write_Data / Y width
//  ADDR_W  3   register address width (8 registers)
//  IMM_W   5   immediate width (imm5)
// PORTS
//  clk           in   1       single clock, all state on rising edge
//  rst           in   1       synchronous reset, active-high
//  instr_valid   in   1       instruction offered
//  instr_ready   out  1       sequencer can accept (state IDLE)
//  instr_op      in   2       [0]=ALU_Operator (0 add, 1 sub); [1]=Src_ALU_B (1 imm)
//  instr_rd      in   ADDR_W  destination register
//  instr_rs      in   ADDR_W  source A
//  instr_rt      in   ADDR_W  source B (ignored when op[1]=1)
//  instr_imm     in   IMM_W   immediate
//  Read_Addr_A   out  ADDR_W  to RF_plus_ALU
//  Read_Addr_B   out  ADDR_W  to RF_plus_ALU
//  ALU_Operator  out  1       to RF_plus_ALU
//  Src_ALU_B     out  1       to RF_plus_ALU
//  imm5          out  IMM_W   to RF_plus_ALU
//  Y             in   DATA_W  ALU result from RF_plus_ALU
//  Z,N,C,V       in   1 each  ALU flags from RF_plus_ALU
//  Write_En      out  1       RF write enable
//  Write_Addr    out  ADDR_W  RF write address
//  Write_Data    out  DATA_W  RF write data
//  flags_q       out  4       {Z,N,C,V} of last completed instruction
//  done          out  1       1-cycle pulse per completed instruction
// BEHAVIOUR
//  - FSM IDLE -> ISSUE -> CAPT -> WB -> IDLE; accept on instr_valid&&instr_ready.
//  - Accept edge latches op/rd/rs/rt/imm into instr reg; read/ALU-control outputs
//    are driven from this reg and held stable through ISSUE, CAPT, WB.
//  - ISSUE: ALU settles (combinational). CAPT edge: Y -> y_q, {Z,N,C,V} -> flags_q.
//  - WB: Write_En=1 exactly one cycle, Write_Addr=rd, Write_Data=y_q; RF writes on
//    the edge leaving WB. done=1 in the following IDLE cycle (registered).
//  - Accept-to-accept min 4 cycles; next ISSUE always sees prior writeback, so no
//    RAW hazard handling needed. rd may equal rs/rt; r0 is an ordinary register.
//  - Write_En = (state==WB) && !rst: no RF write on a reset edge.
//  - Reset (any state, incl. mid-op): state IDLE, all outputs 0, flags_q=0,
//    done=0, instr_ready=1 from the cycle after the reset edge; op discarded.
//  - instr_valid with busy sequencer: ignored (held by source, not dropped).
// CONFIGURATION
//  RFSEQ_CMP_EN defined: extra input instr_cmp (1b) latched at accept; when 1,
//    CAPT -> IDLE directly (flags_q updated, no Write_En, done still pulses).
//  Undefined: port absent, every instruction writes back.
// TESTING (bench pairs with behavioural RF+ALU model preloaded r1=0x0034, r2=0x0056)
//  1 rst 2 cycles -> instr_ready=1, Write_En=0, flags_q=0, done=0, addr outs 0.
//  2 ADD rd=3 rs=2 rt=1 -> Write_En 1 cycle, Write_Addr=3, Write_Data=0x008A,
//    flags Z=0 N=0, done 4 cycles after accept.
//  3 SUB rd=4 rs=1 rt=2 -> Write_Data=0xFFDE, N=1, Z=0.
//  4 ADDI rd=5 rs=2 imm=1 -> Src_ALU_B=1, imm5=1 held ISSUE..WB, Write_Data=0x0057.
//  5 back-to-back ADD rd=6 rs=1 rt=1 then ADD rd=7 rs=6 rt=1 (valid held) ->
//    accepts 4 cycles apart, r7=0x009C; rst in CAPT -> no Write_En, no done.
//  6 RFSEQ_CMP_EN: SUB cmp=1 rs=1 rt=1 -> Z=1, no Write_En, done pulses.

Source files
------------

// File: rtl/rf_alu_sequencer.sv
// Multi-cycle initiator for RF_plus_ALU: accept, issue, capture Y/flags, write back.
// Optional compare-only instructions are enabled with the RFSEQ_CMP_EN macro.
module rf_alu_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int IMM_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [1:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_rs,
    input  logic [ADDR_W-1:0] instr_rt,
    input  logic [IMM_W-1:0]  instr_imm,
`ifdef RFSEQ_CMP_EN
    input  logic              instr_cmp,
`endif
    output logic [ADDR_W-1:0] Read_Addr_A,
    output logic [ADDR_W-1:0] Read_Addr_B,
    output logic              ALU_Operator,
    output logic              Src_ALU_B,
    output logic [IMM_W-1:0]  imm5,
    input  logic [DATA_W-1:0] Y,
    input  logic              Z,
    input  logic              N,
    input  logic              C,
    input  logic              V,
    output logic              Write_En,
    output logic [ADDR_W-1:0] Write_Addr,
    output logic [DATA_W-1:0] Write_Data,
    output logic [3:0]        flags_q,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, WB} state_t;

    state_t              state_reg, state_next;
    logic [1:0]          op_reg;
    logic [ADDR_W-1:0]   rd_reg, rs_reg, rt_reg;
    logic [IMM_W-1:0]    imm_reg;
    logic [DATA_W-1:0]   y_reg;
    logic [3:0]          flags_reg;
    logic                done_reg;
    logic                accept;
    logic                wb_skip;

`ifdef RFSEQ_CMP_EN
    logic cmp_reg;

    always_ff @(posedge clk) begin
        if (rst)
            cmp_reg <= 1'b0;
        else if (accept)
            cmp_reg <= instr_cmp;
    end

    assign wb_skip = cmp_reg;
`else
    assign wb_skip = 1'b0;
`endif

    assign accept = (state_reg == IDLE) && instr_valid;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (instr_valid) state_next = ISSUE;
            ISSUE:   state_next = CAPT;
            CAPT:    state_next = wb_skip ? IDLE : WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The ALU is combinational on the held read addresses, so Y is stable by the CAPT edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            op_reg    <= '0;
            rd_reg    <= '0;
            rs_reg    <= '0;
            rt_reg    <= '0;
            imm_reg   <= '0;
            y_reg     <= '0;
            flags_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg  <= instr_op;
                rd_reg  <= instr_rd;
                rs_reg  <= instr_rs;
                rt_reg  <= instr_rt;
                imm_reg <= instr_imm;
            end
            if (state_reg == CAPT) begin
                y_reg     <= Y;
                flags_reg <= {Z, N, C, V};
            end
            done_reg <= (state_reg == WB) || ((state_reg == CAPT) && wb_skip);
        end
    end

    assign instr_ready  = (state_reg == IDLE);
    assign Read_Addr_A  = rs_reg;
    assign Read_Addr_B  = rt_reg;
    assign ALU_Operator = op_reg[0];
    assign Src_ALU_B    = op_reg[1];
    assign imm5         = imm_reg;
    // Gated by rst so a reset arriving during WB never commits a write.
    assign Write_En     = (state_reg == WB) && !rst;
    assign Write_Addr   = rd_reg;
    assign Write_Data   = y_reg;
    assign flags_q      = flags_reg;
    assign done         = done_reg;

endmodule
